// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage : lsu_pkg

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering for stores, load extract/extend, fault decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [2:0]        req_funct3_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_off_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic [BE_W-1:0]   req_be_o,
    output logic [DWIDTH-1:0] req_wdata_o,
    output logic              req_fault_o,
    input  logic [2:0]        rsp_funct3_i,
    input  logic [1:0]        rsp_off_i,
    input  logic [DWIDTH-1:0] rsp_rdata_i,
    output logic [DWIDTH-1:0] rsp_data_o
);

    logic [DWIDTH-1:0] w_shifted;

    always_comb begin
        req_be_o    = '0;
        req_wdata_o = req_wdata_i;
        req_fault_o = 1'b0;
        case (req_funct3_i)
            F3_B, F3_BU: begin
                req_be_o    = 4'b0001 << req_off_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                req_be_o    = 4'b0011 << req_off_i;
                req_wdata_o = {2{req_wdata_i[15:0]}};
                req_fault_o = req_off_i[0];
            end
            F3_W: begin
                req_be_o    = 4'b1111;
                req_fault_o = |req_off_i;
            end
            default: req_fault_o = 1'b1;
        endcase
        // Stores have no unsigned variants, so funct3[2] is always illegal for them
        if (req_we_i && req_funct3_i[2]) begin
            req_fault_o = 1'b1;
        end
    end

    always_comb begin
        w_shifted = rsp_rdata_i >> {rsp_off_i, 3'b000};
        case (rsp_funct3_i)
            F3_B:    rsp_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   rsp_data_o = {24'd0, w_shifted[7:0]};
            F3_H:    rsp_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   rsp_data_o = {16'd0, w_shifted[15:0]};
            default: rsp_data_o = w_shifted;
        endcase
    end

endmodule : lsu_align

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store FSM driving a request/ready data-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic              Lsu_Req,
    input  logic              Lsu_We,
    input  logic [2:0]        Lsu_Funct3,
    input  logic [DWIDTH-1:0] Lsu_Addr,
    input  logic [DWIDTH-1:0] Lsu_Store_Data,
    output logic              Lsu_Stall,
    output logic [DWIDTH-1:0] Lsu_Load_Data,
    output logic              Lsu_Fault,
    output logic              Dmem_Req,
    output logic              Dmem_We,
    output logic [DWIDTH-1:0] Dmem_Addr,
    output logic [BE_W-1:0]   Dmem_Be,
    output logic [DWIDTH-1:0] Dmem_Wdata,
    input  logic              Dmem_Ready,
    input  logic [DWIDTH-1:0] Dmem_Rdata
);

    lsu_state_t        state_q, state_d;
    logic              fault_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              dmem_req_q, dmem_we_q;
    logic [DWIDTH-1:0] dmem_addr_q, dmem_wdata_q, load_data_q;
    logic [BE_W-1:0]   dmem_be_q;

    logic [BE_W-1:0]   w_be;
    logic [DWIDTH-1:0] w_wdata;
    logic [DWIDTH-1:0] w_load;
    logic              w_fault;

    lsu_align #(
        .DWIDTH(DWIDTH)
    ) u_align (
        .req_funct3_i (Lsu_Funct3),
        .req_we_i     (Lsu_We),
        .req_off_i    (Lsu_Addr[1:0]),
        .req_wdata_i  (Lsu_Store_Data),
        .req_be_o     (w_be),
        .req_wdata_o  (w_wdata),
        .req_fault_o  (w_fault),
        .rsp_funct3_i (funct3_q),
        .rsp_off_i    (off_q),
        .rsp_rdata_i  (Dmem_Rdata),
        .rsp_data_o   (w_load)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Lsu_Req) state_d = w_fault ? DONE : BUSY;
            BUSY:    if (Dmem_Ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            state_q      <= IDLE;
            fault_q      <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            load_data_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Lsu_Req) begin
                        if (w_fault) begin
                            fault_q     <= 1'b1;
                            load_data_q <= '0;
                        end else begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= Lsu_We;
                            dmem_addr_q  <= {Lsu_Addr[DWIDTH-1:2], 2'b00};
                            dmem_be_q    <= w_be;
                            dmem_wdata_q <= w_wdata;
                            funct3_q     <= Lsu_Funct3;
                            off_q        <= Lsu_Addr[1:0];
                        end
                    end
                end
                BUSY: begin
                    if (Dmem_Ready) begin
                        dmem_req_q <= 1'b0;
                        if (!dmem_we_q) begin
                            load_data_q <= w_load;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // DONE is the retiring cycle: the held request must not stall it
    assign Lsu_Stall     = Lsu_Req && (state_q != DONE);
    assign Lsu_Load_Data = load_data_q;
    assign Lsu_Fault     = fault_q;
    assign Dmem_Req      = dmem_req_q;
    assign Dmem_We       = dmem_we_q;
    assign Dmem_Addr     = dmem_addr_q;
    assign Dmem_Be       = dmem_be_q;
    assign Dmem_Wdata    = dmem_wdata_q;

endmodule : load_store_unit

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a wait-state memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] addr, sdata;
    logic        stall, fault;
    logic [31:0] ldata;
    logic        dmem_req, dmem_we;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;
    logic        resp_ready, force_ready;
    logic        dready;
    logic [31:0] drdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign dready = resp_ready | force_ready;

    load_store_unit #(.DWIDTH(32)) dut (
        .Clk_Core       (clk),
        .Rst_Core       (rst),
        .Lsu_Req        (req),
        .Lsu_We         (we),
        .Lsu_Funct3     (f3),
        .Lsu_Addr       (addr),
        .Lsu_Store_Data (sdata),
        .Lsu_Stall      (stall),
        .Lsu_Load_Data  (ldata),
        .Lsu_Fault      (fault),
        .Dmem_Req       (dmem_req),
        .Dmem_We        (dmem_we),
        .Dmem_Addr      (daddr),
        .Dmem_Be        (dbe),
        .Dmem_Wdata     (dwdata),
        .Dmem_Ready     (dready),
        .Dmem_Rdata     (drdata)
    );

    typedef struct {
        string       name;
        logic        we;
        logic        mem;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        flt;
        int          stall;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: answers after mem_waits wait cycles
    int          mem_waits = 0;
    logic [31:0] mem_rdata = '0;
    int          wcnt = 0;
    initial begin
        resp_ready = 1'b0;
        drdata     = '0;
    end
    always @(negedge clk) begin
        resp_ready = 1'b0;
        if (dmem_req && !rst) begin
            if (wcnt >= mem_waits) begin
                resp_ready = 1'b1;
                drdata     = mem_rdata;
                wcnt       = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: tracks the bus during a transaction, pops on retirement
    bit          mon_en = 0;
    bit          seen = 0, unstable = 0, fault_next = 0;
    int          stall_cnt = 0;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    exp_t        m_e;
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            seen = 0; unstable = 0; stall_cnt = 0; fault_next = 0;
        end else begin
            if (fault_next) begin
                chk("fault_pulse_end", {31'd0, fault}, 32'd0);
                fault_next = 0;
            end
            if (dmem_req) begin
                if (!seen) begin
                    seen = 1; c_addr = daddr; c_wdata = dwdata; c_be = dbe; c_we = dmem_we;
                end else if (daddr !== c_addr || dwdata !== c_wdata || dbe !== c_be || dmem_we !== c_we) begin
                    unstable = 1;
                end
            end
            if (req && stall) stall_cnt++;
            if (req && !stall) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_empty: got retirement expected none");
                end else begin
                    m_e = sbq.pop_front();
                    chk({m_e.name, "_fault"}, {31'd0, fault}, {31'd0, m_e.flt});
                    chk({m_e.name, "_ldata"}, ldata, m_e.ld);
                    chk({m_e.name, "_memreq"}, {31'd0, seen}, {31'd0, m_e.mem});
                    chk({m_e.name, "_stall"}, stall_cnt, m_e.stall);
                    if (m_e.mem) begin
                        chk({m_e.name, "_stable"}, {31'd0, unstable}, 32'd0);
                        chk({m_e.name, "_addr"}, c_addr, m_e.addr);
                        chk({m_e.name, "_we"}, {31'd0, c_we}, {31'd0, m_e.we});
                        if (m_e.we) begin
                            chk({m_e.name, "_be"}, {28'd0, c_be}, {28'd0, m_e.be});
                            chk({m_e.name, "_wdata"}, c_wdata, m_e.wdata);
                        end
                    end
                end
                fault_next = 1; seen = 0; unstable = 0; stall_cnt = 0;
            end
        end
    end

    task automatic access(string nm, logic w, logic [2:0] fn, logic [31:0] a, logic [31:0] sd,
                          logic [31:0] rd, int waits, logic mem, logic [31:0] eaddr,
                          logic [3:0] ebe, logic [31:0] ewd, logic [31:0] eld, logic eflt);
        exp_t e;
        int   n;
        e.name = nm; e.we = w; e.mem = mem; e.addr = eaddr; e.be = ebe; e.wdata = ewd;
        e.ld = eld; e.flt = eflt; e.stall = mem ? 2 + waits : 1;
        sbq.push_back(e);
        mem_waits = waits; mem_rdata = rd;
        req = 1'b1; we = w; f3 = fn; addr = a; sdata = sd;
        n = 0;
        @(negedge clk);
        while (stall && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            total++; bad++;
            $display("FAIL %s_timeout: got stall still high expected release", nm);
            sbq.delete();
            req = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            @(posedge clk); #1;
            req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; f3 = '0; addr = '0; sdata = '0; force_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_be", {28'd0, dbe}, 32'd0);
        chk("rst_dmem_addr", daddr, 32'd0);
        chk("rst_ldata", ldata, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1;

        //     name     we    f3     addr          sdata         rdata         w  mem  eaddr         be     wdata         ld            flt
        access("lw",    1'b0, F3_W,  32'h104, 32'h0,         32'hDEADBEEF, 0, 1, 32'h104, 4'hF, 32'h0,         32'hDEADBEEF, 0);
        access("lb",    1'b0, F3_B,  32'h103, 32'h0,         32'h80FFFF00, 0, 1, 32'h100, 4'h0, 32'h0,         32'hFFFFFF80, 0);
        access("lbu",   1'b0, F3_BU, 32'h103, 32'h0,         32'h80FFFF00, 0, 1, 32'h100, 4'h0, 32'h0,         32'h00000080, 0);
        access("lhu",   1'b0, F3_HU, 32'h102, 32'h0,         32'h80FFFF00, 0, 1, 32'h100, 4'h0, 32'h0,         32'h000080FF, 0);
        access("lh",    1'b0, F3_H,  32'h102, 32'h0,         32'h80FFFF00, 0, 1, 32'h100, 4'h0, 32'h0,         32'hFFFF80FF, 0);
        access("lh0",   1'b0, F3_H,  32'h100, 32'h0,         32'h12347FFE, 0, 1, 32'h100, 4'h0, 32'h0,         32'h00007FFE, 0);
        access("lb1",   1'b0, F3_B,  32'h101, 32'h0,         32'h12347FFE, 0, 1, 32'h100, 4'h0, 32'h0,         32'h0000007F, 0);
        access("sh",    1'b1, F3_H,  32'h202, 32'h1234ABCD,  32'h0,        0, 1, 32'h200, 4'hC, 32'hABCDABCD,  32'h0000007F, 0);
        access("sb",    1'b1, F3_B,  32'h201, 32'h000000A5,  32'h0,        0, 1, 32'h200, 4'h2, 32'hA5A5A5A5,  32'h0000007F, 0);
        access("lw_mis",1'b0, F3_W,  32'h101, 32'h0,         32'h0,        0, 0, 32'h0,   4'h0, 32'h0,         32'h00000000, 1);
        access("sw_w5", 1'b1, F3_W,  32'h300, 32'hCAFEF00D,  32'h0,        5, 1, 32'h300, 4'hF, 32'hCAFEF00D,  32'h00000000, 0);
        access("lw_w2", 1'b0, F3_W,  32'h108, 32'h0,         32'h11223344, 2, 1, 32'h108, 4'h0, 32'h0,         32'h11223344, 0);
        access("lbu2",  1'b0, F3_BU, 32'h10A, 32'h0,         32'h11223344, 0, 1, 32'h108, 4'h0, 32'h0,         32'h00000022, 0);
        access("sh_mis",1'b1, F3_H,  32'h203, 32'h0,         32'h0,        0, 0, 32'h0,   4'h0, 32'h0,         32'h00000000, 1);
        access("ld_f3", 1'b0, 3'd3,  32'h100, 32'h0,         32'h0,        0, 0, 32'h0,   4'h0, 32'h0,         32'h00000000, 1);
        access("st_f3", 1'b1, 3'd4,  32'h100, 32'h0,         32'h0,        0, 0, 32'h0,   4'h0, 32'h0,         32'h00000000, 1);
        access("lhu2",  1'b0, F3_HU, 32'h106, 32'h0,         32'hFEDC1234, 0, 1, 32'h104, 4'h0, 32'h0,         32'h0000FEDC, 0);

        // Reset while BUSY abandons the access
        mon_en = 0;
        mem_waits = 100; mem_rdata = 32'hFFFFFFFF;
        req = 1'b1; we = 1'b1; f3 = F3_W; addr = 32'h400; sdata = 32'h55AA55AA;
        @(negedge clk);
        @(negedge clk);
        chk("busy_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_we", {31'd0, dmem_we}, 32'd0);
        chk("mid_rst_addr", daddr, 32'd0);
        chk("mid_rst_be", {28'd0, dbe}, 32'd0);
        chk("mid_rst_wdata", dwdata, 32'd0);
        chk("mid_rst_ldata", ldata, 32'd0);
        chk("mid_rst_fault", {31'd0, fault}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        force_ready = 1'b1;
        @(posedge clk); #1;
        force_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_req", {31'd0, dmem_req}, 32'd0);
        chk("late_ready_ldata", ldata, 32'd0);
        chk("late_ready_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        mon_en = 1;
        mem_waits = 0;
        access("lw_post", 1'b0, F3_W, 32'h10C, 32'h0, 32'h0BADF00D, 0, 1, 32'h10C, 4'h0, 32'h0, 32'h0BADF00D, 0);
        @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_load_store_unit

`default_nettype wire
